// File: rtl/rcu_seq_pkg.sv
// Shared definitions for the RCU reset/clock-enable sequencer: register word
// offsets (paddr[5:2]), register bit positions and FSM state encodings.
package rcu_seq_pkg;

    localparam logic [3:0] REG_CTRL     = 4'h0;
    localparam logic [3:0] REG_STAT     = 4'h1;
    localparam logic [3:0] REG_DLY      = 4'h2;
    localparam logic [3:0] REG_DIV_BASE = 4'h4;

    localparam int CTRL_START  = 0;
    localparam int CTRL_ASSERT = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_LOCK    = 2;
    localparam int STAT_TIMEOUT = 3;
    localparam int STAT_RST_N   = 8;

    typedef logic [1:0] seq_state_t;

    localparam seq_state_t ST_IDLE      = 2'd0;
    localparam seq_state_t ST_WAIT_LOCK = 2'd1;
    localparam seq_state_t ST_REL       = 2'd2;
    localparam seq_state_t ST_GAP       = 2'd3;

    localparam logic [15:0] TIMEOUT_LAST = 16'hFFFE;

endpackage

// File: rtl/rcu_clk_en_div.sv
// One channel of the clock-enable divider: a pulse every DIV+1 cycles while
// the channel's reset is released, first pulse on the first released cycle.
module rcu_clk_en_div #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 i_rst_n,
    input  logic                 i_restart,
    input  logic [DIV_WIDTH-1:0] i_div,
    input  logic [DIV_WIDTH-1:0] i_restart_div,
    output logic                 o_clk_en
);

    logic [DIV_WIDTH-1:0] r_cnt;

    // Down-counter firing at zero; a restart reloads as if a pulse had just fired.
    always_ff @(posedge clk_i) begin
        if (rst_i || !i_rst_n) begin
            r_cnt <= '0;
        end else if (i_restart) begin
            r_cnt <= i_restart_div;
        end else if (r_cnt == '0) begin
            r_cnt <= i_div;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_clk_en = i_rst_n && (r_cnt == '0);

endmodule

// File: rtl/rcu_rst_seq.sv
// RCU reset-release sequencer with per-channel clock-enable dividers and APB4 slave.
// Optional lock timeout in WAIT_LOCK enabled by defining RCU_SEQ_TIMEOUT_EN.
//
// state      | meaning
// IDLE       | no sequence running; START accepted here
// WAIT_LOCK  | waiting for pll_lock_i before the first release
// REL        | releasing channel idx this cycle
// GAP        | counting DLY cycles between two releases
module rcu_rst_seq
    import rcu_seq_pkg::*;
#(
    parameter int CHAN_NUM  = 4,
    parameter int DLY_WIDTH = 8,
    parameter int DIV_WIDTH = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                psel_i,
    input  logic                penable_i,
    input  logic                pwrite_i,
    input  logic [5:0]          paddr_i,
    input  logic [31:0]         pwdata_i,
    output logic [31:0]         prdata_o,
    output logic                pready_o,
    output logic                pslverr_o,
    input  logic                sys_rst_req_i,
    input  logic                pll_lock_i,
    output logic [CHAN_NUM-1:0] rst_n_o,
    output logic [CHAN_NUM-1:0] clk_en_o,
    output logic                busy_o,
    output logic                irq_o
);

    localparam int IDX_W = (CHAN_NUM > 1) ? $clog2(CHAN_NUM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHAN_NUM - 1);

    logic                w_wr;
    logic                w_rd;
    logic [3:0]          w_addr;
    logic                w_ctrl_wr;
    logic                w_stat_wr;
    logic                w_dly_wr;
    logic [CHAN_NUM-1:0] w_div_wr;
    logic                w_auto_start;
    logic                w_start;
    logic                w_assert;
    logic                w_kill;
    logic                w_done_set;
    logic                w_timeout_set;
    logic [31:0]         w_rdata;
    logic                w_unused;

    seq_state_t           r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [DLY_WIDTH-1:0] r_gap_cnt;
    logic [DLY_WIDTH-1:0] r_dly;
    logic [CHAN_NUM-1:0]  r_rst_n;
    logic                 r_done;
    logic                 r_timeout;
    logic                 r_irq_en;
    logic                 r_irq;
    logic                 r_sys_rst_q;
    logic [DIV_WIDTH-1:0] r_div [CHAN_NUM];

    assign w_wr      = psel_i & penable_i & pwrite_i;
    assign w_rd      = psel_i & penable_i & ~pwrite_i;
    assign w_addr    = paddr_i[5:2];
    assign w_ctrl_wr = w_wr && (w_addr == REG_CTRL);
    assign w_stat_wr = w_wr && (w_addr == REG_STAT);
    assign w_dly_wr  = w_wr && (w_addr == REG_DLY);
    assign w_unused  = ^{paddr_i[1:0], pwdata_i};

    // Release of an external/watchdog reset restarts the sequence on its own.
    assign w_auto_start = r_sys_rst_q & ~sys_rst_req_i;
    assign w_start      = (w_ctrl_wr & pwdata_i[CTRL_START]) | w_auto_start;
    assign w_assert     = w_ctrl_wr & pwdata_i[CTRL_ASSERT];
    assign w_kill       = sys_rst_req_i | w_assert;
    assign w_done_set   = (r_state == ST_REL) && (r_idx == LAST_IDX) && !w_kill;

`ifdef RCU_SEQ_TIMEOUT_EN
    logic [15:0] r_to_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || (r_state != ST_WAIT_LOCK)) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end
    end

    assign w_timeout_set = (r_state == ST_WAIT_LOCK) && !pll_lock_i &&
                           (r_to_cnt == TIMEOUT_LAST) && !w_kill;
`else
    assign w_timeout_set = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i || w_kill) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_gap_cnt <= '0;
            r_rst_n   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) r_state <= ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (pll_lock_i)         r_state <= ST_REL;
                    else if (w_timeout_set) r_state <= ST_IDLE;
                end
                ST_REL: begin
                    r_rst_n[r_idx] <= 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_state <= ST_IDLE;
                        r_idx   <= '0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                        if (r_dly != '0) begin
                            r_state   <= ST_GAP;
                            r_gap_cnt <= r_dly;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == DLY_WIDTH'(1)) begin
                        r_state   <= ST_REL;
                        r_gap_cnt <= '0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sys_rst_q <= 1'b0;
            r_irq_en    <= 1'b0;
            r_dly       <= '0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_irq       <= 1'b0;
            for (int i = 0; i < CHAN_NUM; i++) r_div[i] <= '0;
        end else begin
            r_sys_rst_q <= sys_rst_req_i;
            if (w_ctrl_wr) r_irq_en <= pwdata_i[CTRL_IRQ_EN];
            if (w_dly_wr)  r_dly    <= pwdata_i[DLY_WIDTH-1:0];
            // A set in the same cycle as its W1C keeps the flag.
            if (w_done_set)                             r_done <= 1'b1;
            else if (w_stat_wr && pwdata_i[STAT_DONE])  r_done <= 1'b0;
            if (w_timeout_set)                             r_timeout <= 1'b1;
            else if (w_stat_wr && pwdata_i[STAT_TIMEOUT])  r_timeout <= 1'b0;
            r_irq <= r_irq_en & (r_done | r_timeout);
            for (int i = 0; i < CHAN_NUM; i++) begin
                if (w_div_wr[i]) r_div[i] <= pwdata_i[DIV_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_rd) begin
            case (w_addr)
                REG_CTRL: w_rdata[CTRL_IRQ_EN] = r_irq_en;
                REG_STAT: begin
                    w_rdata[STAT_BUSY]                = (r_state != ST_IDLE);
                    w_rdata[STAT_DONE]                = r_done;
                    w_rdata[STAT_LOCK]                = pll_lock_i;
                    w_rdata[STAT_TIMEOUT]             = r_timeout;
                    w_rdata[STAT_RST_N +: CHAN_NUM]   = r_rst_n;
                end
                REG_DLY: w_rdata[DLY_WIDTH-1:0] = r_dly;
                default: begin
                    for (int i = 0; i < CHAN_NUM; i++) begin
                        if (w_addr == REG_DIV_BASE + 4'(i)) w_rdata[DIV_WIDTH-1:0] = r_div[i];
                    end
                end
            endcase
        end
    end

    for (genvar g = 0; g < CHAN_NUM; g++) begin : g_chan
        assign w_div_wr[g] = w_wr && (w_addr == REG_DIV_BASE + 4'(g));

        rcu_clk_en_div #(
            .DIV_WIDTH (DIV_WIDTH)
        ) u_div (
            .clk_i         (clk_i),
            .rst_i         (rst_i),
            .i_rst_n       (r_rst_n[g]),
            .i_restart     (w_div_wr[g]),
            .i_div         (r_div[g]),
            .i_restart_div (pwdata_i[DIV_WIDTH-1:0]),
            .o_clk_en      (clk_en_o[g])
        );
    end

    assign prdata_o  = w_rdata;
    assign pready_o  = 1'b1;
    assign pslverr_o = 1'b0;
    assign rst_n_o   = r_rst_n;
    assign busy_o    = (r_state != ST_IDLE);
    assign irq_o     = r_irq;

endmodule

// File: tb/tb_rcu_rst_seq.sv
// Directed bench for rcu_rst_seq: expectations queued at stimulus time,
// popped and compared when the DUT output is sampled on the falling edge.
module tb_rcu_rst_seq;

    localparam int N = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        psel_i = 1'b0;
    logic        penable_i = 1'b0;
    logic        pwrite_i = 1'b0;
    logic [5:0]  paddr_i = '0;
    logic [31:0] pwdata_i = '0;
    logic [31:0] prdata_o;
    logic        pready_o;
    logic        pslverr_o;
    logic        sys_rst_req_i = 1'b0;
    logic        pll_lock_i = 1'b0;
    logic [N-1:0] rst_n_o;
    logic [N-1:0] clk_en_o;
    logic        busy_o;
    logic        irq_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    logic [31:0] rd_data;
    logic [3:0]  ce_exp;

    rcu_rst_seq #(.CHAN_NUM(N), .DLY_WIDTH(8), .DIV_WIDTH(8)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .psel_i        (psel_i),
        .penable_i     (penable_i),
        .pwrite_i      (pwrite_i),
        .paddr_i       (paddr_i),
        .pwdata_i      (pwdata_i),
        .prdata_o      (prdata_o),
        .pready_o      (pready_o),
        .pslverr_o     (pslverr_o),
        .sys_rst_req_i (sys_rst_req_i),
        .pll_lock_i    (pll_lock_i),
        .rst_n_o       (rst_n_o),
        .clk_en_o      (clk_en_o),
        .busy_o        (busy_o),
        .irq_o         (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL sb_empty observed=0x%0h expected=<queued entry>", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.exp);
        end
    endtask

    task automatic apb_write(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk_i);
        psel_i = 1'b1; pwrite_i = 1'b1; paddr_i = a; pwdata_i = d; penable_i = 1'b0;
        @(negedge clk_i);
        penable_i = 1'b1;
        @(negedge clk_i);
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    endtask

    task automatic apb_read(input logic [5:0] a, output logic [31:0] d);
        @(negedge clk_i);
        psel_i = 1'b1; pwrite_i = 1'b0; paddr_i = a; penable_i = 1'b0;
        @(negedge clk_i);
        penable_i = 1'b1;
        #1 d = prdata_o;
        @(negedge clk_i);
        psel_i = 1'b0; penable_i = 1'b0;
    endtask

    task automatic read_check(input logic [5:0] a, input string tag, input logic [31:0] exp);
        logic [31:0] d;
        push(tag, exp);
        apb_read(a, d);
        pop_check(d);
    endtask

    // {busy, clk_en, rst_n} k cycles after the reference edge, all DIV = 0:
    // channel j released at base + j*(DLY+1), busy from base-2 until the last release.
    function automatic logic [8:0] exp_seq(input int k, input int d, input int base);
        logic [3:0] rn;
        rn = '0;
        for (int j = 0; j < N; j++) if (k >= base + j * (d + 1)) rn[j] = 1'b1;
        return {(k >= base - 2) && (k < base + (N - 1) * (d + 1)), rn, rn};
    endfunction

    initial begin
        // reset state
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        push("rst_outputs", 32'h0);
        pop_check(32'({busy_o, irq_o, clk_en_o, rst_n_o}));
        push("pready", 32'h1);
        pop_check(32'(pready_o));
        push("pslverr", 32'h0);
        pop_check(32'(pslverr_o));
        read_check(6'h00, "rst_ctrl", 32'h0);
        read_check(6'h04, "rst_stat", 32'h0);
        read_check(6'h08, "rst_dly", 32'h0);
        for (int i = 0; i < N; i++) read_check(6'(16 + 4 * i), $sformatf("rst_div%0d", i), 32'h0);
        read_check(6'h0C, "unmapped_0c", 32'h0);

        // program gap and IRQ enable
        apb_write(6'h08, 32'h3);
        apb_write(6'h00, 32'h4);
        read_check(6'h08, "dly_rb", 32'h3);
        read_check(6'h00, "ctrl_rb", 32'h4);
        read_check(6'h3C, "unmapped_3c", 32'h0);
        push("prdata_idle", 32'h0);
        pop_check(prdata_o);

        // DLY=3 release sequence with lock already present
        pll_lock_i = 1'b1;
        apb_write(6'h00, 32'h5);
        for (int k = 0; k <= 16; k++) push($sformatf("seq_d3_k%0d", k), 32'(exp_seq(k, 3, 2)));
        for (int k = 0; k <= 16; k++) begin
            pop_check(32'({busy_o, clk_en_o, rst_n_o}));
            @(negedge clk_i);
        end
        push("irq_done", 32'h1);
        pop_check(32'(irq_o));
        read_check(6'h04, "stat_done", 32'h0000_0F06);
        apb_write(6'h04, 32'h2);
        @(negedge clk_i);
        push("irq_w1c", 32'h0);
        pop_check(32'(irq_o));
        read_check(6'h04, "stat_w1c", 32'h0000_0F04);

        // divider: DIV1=0 constant, DIV0=2 every 3rd cycle, then DIV0=4 rewrite
        apb_write(6'h14, 32'h0);
        apb_write(6'h10, 32'h2);
        for (int k = 0; k <= 8; k++) begin
            ce_exp = 4'b1110;
            ce_exp[0] = (k % 3 == 2);
            push($sformatf("div2_k%0d", k), 32'(ce_exp));
        end
        for (int k = 0; k <= 8; k++) begin
            pop_check(32'(clk_en_o));
            @(negedge clk_i);
        end
        apb_write(6'h10, 32'h4);
        for (int k = 0; k <= 10; k++) begin
            ce_exp = 4'b1110;
            ce_exp[0] = (k % 5 == 4);
            push($sformatf("div4_k%0d", k), 32'(ce_exp));
        end
        for (int k = 0; k <= 10; k++) begin
            pop_check(32'(clk_en_o));
            @(negedge clk_i);
        end
        apb_write(6'h10, 32'h0);

        // ASSERT, then START without lock: holds in WAIT_LOCK
        apb_write(6'h00, 32'h6);
        push("assert_clears", 32'h0);
        pop_check(32'({busy_o, clk_en_o, rst_n_o}));
        pll_lock_i = 1'b0;
        apb_write(6'h08, 32'h0);
        apb_write(6'h00, 32'h5);
        for (int k = 0; k < 50; k++) push($sformatf("nolock_k%0d", k), 32'h100);
        for (int k = 0; k < 50; k++) begin
            pop_check(32'({busy_o, clk_en_o, rst_n_o}));
            @(negedge clk_i);
        end
        pll_lock_i = 1'b1;
        for (int k = 0; k <= 6; k++) push($sformatf("lock_d0_k%0d", k), 32'(exp_seq(k, 0, 2)));
        for (int k = 0; k <= 6; k++) begin
            pop_check(32'({busy_o, clk_en_o, rst_n_o}));
            @(negedge clk_i);
        end

        // sys_rst_req mid-GAP, then automatic restart on its falling edge
        apb_write(6'h00, 32'h6);
        apb_write(6'h08, 32'h3);
        apb_write(6'h00, 32'h5);
        for (int k = 0; k <= 7; k++) push($sformatf("pre_kill_k%0d", k), 32'(exp_seq(k, 3, 2)));
        for (int k = 0; k < 7; k++) begin
            pop_check(32'({busy_o, clk_en_o, rst_n_o}));
            @(negedge clk_i);
        end
        pop_check(32'({busy_o, clk_en_o, rst_n_o}));
        sys_rst_req_i = 1'b1;
        for (int k = 8; k <= 12; k++) push($sformatf("kill_k%0d", k), 32'h0);
        for (int k = 8; k <= 12; k++) begin
            @(negedge clk_i);
            pop_check(32'({busy_o, clk_en_o, rst_n_o}));
        end
        sys_rst_req_i = 1'b0;
        for (int k = 1; k <= 15; k++) push($sformatf("auto_k%0d", k), 32'(exp_seq(k, 3, 3)));
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk_i);
            pop_check(32'({busy_o, clk_en_o, rst_n_o}));
        end

        // START with every channel already released: re-runs, outputs stay high
        apb_write(6'h00, 32'h5);
        for (int k = 0; k <= 14; k++) push($sformatf("rerun_k%0d", k), 32'(exp_seq(k, 3, 2) | 9'h0FF));
        for (int k = 0; k <= 14; k++) begin
            pop_check(32'({busy_o, clk_en_o, rst_n_o}));
            @(negedge clk_i);
        end

`ifdef RCU_SEQ_TIMEOUT_EN
        apb_write(6'h00, 32'h6);
        apb_write(6'h04, 32'h2);
        pll_lock_i = 1'b0;
        apb_write(6'h00, 32'h5);
        push("to_busy_65534", 32'h100);
        push("to_idle_65535", 32'h0);
        push("to_irq", 32'h1);
        repeat (65534) @(negedge clk_i);
        pop_check(32'({busy_o, clk_en_o, rst_n_o}));
        @(negedge clk_i);
        pop_check(32'({busy_o, clk_en_o, rst_n_o}));
        @(negedge clk_i);
        pop_check(32'(irq_o));
        read_check(6'h04, "to_stat", 32'h0000_0008);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rcu_rst_seq.md
Name: rcu_rst_seq

Overview:
- Next-generation reset/clock-enable controller for the RCU.
- Releases CHAN_NUM reset domains in programmable order-by-index with a programmable gap, gated on PLL lock.
- Generates per-channel divided clock-enable pulses.
- Programmed through a flat APB4 slave; lives in the same clock domain as the RCU register bank.

Parameters:
CHAN_NUM, 4, number of reset/clock-enable channels (1..8)
DLY_WIDTH, 8, width of inter-channel release gap counter
DIV_WIDTH, 8, width of per-channel clock-enable divider

Ports:
clk_i  input  1  block clock
rst_i  input  1  reset, synchronous, active-high
psel_i  input  1  APB4 select
penable_i  input  1  APB4 enable
pwrite_i  input  1  APB4 write
paddr_i  input  6  APB4 byte address; [5:2] decoded
pwdata_i  input  32  APB4 write data
prdata_o  output  32  APB4 read data
pready_o  output  1  tied 1
pslverr_o  output  1  tied 0
sys_rst_req_i  input  1  level reset request (ext OR wdt, pre-synchronised)
pll_lock_i  input  1  PLL lock, pre-synchronised
rst_n_o  output  CHAN_NUM  per-channel active-low reset
clk_en_o  output  CHAN_NUM  per-channel divided clock-enable pulse
busy_o  output  1  sequence in progress
irq_o  output  1  sequence-done (or timeout) interrupt

Behaviour:
- Handshakes: wr = psel&penable&pwrite; rd = psel&penable&~pwrite.
- prdata_o is combinational; it is 0 when not rd or when the address is unmapped.
- Register map:
  - CTRL 0x00: [0] START (write-1 pulse, reads 0); [1] ASSERT (write-1 pulse, reads 0); [2] IRQ_EN (RW, reset 0).
  - STAT 0x04: [0] busy; [1] DONE (sticky, W1C); [2] pll_lock_i; [3] TIMEOUT (W1C); [8+:CHAN_NUM] rst_n_o.
  - DLY 0x08: gap, DLY_WIDTH bits, reset 0.
  - DIVn 0x10+4n: DIV_WIDTH bits, reset 0.
- Reset values: rst_n_o=0, clk_en_o=0, busy_o=0, irq_o=0, FSM=IDLE, channel idx=0.
- FSM states and transitions:
  - IDLE: on START goes to WAIT_LOCK; START is ignored if sys_rst_req_i=1.
  - WAIT_LOCK: goes to REL in the cycle after pll_lock_i=1 is sampled.
  - REL: rst_n_o[idx] goes 1 one cycle after entering REL.
    - If idx==CHAN_NUM-1: go to IDLE, set DONE, idx=0.
    - Else: idx++; go to GAP if DLY>0, otherwise back to REL.
  - GAP: counts DLY cycles, then returns to REL.
  - With DLY=d, consecutive channel releases are d+1 cycles apart; with DLY=0 they are 1 cycle apart.
- busy_o=1 in every state except IDLE.
- ASSERT, or sys_rst_req_i=1: in the next cycle all rst_n_o=0, FSM=IDLE, idx=0; the gap counter is cleared. This works from any state.
- Falling edge of sys_rst_req_i auto-issues START (self-restart after watchdog/ext reset).
- Priority: sys_rst_req_i > ASSERT > START. START while busy is ignored. START with all channels already released re-runs the sequence with no effect on already-high rst_n_o.
- pll_lock_i dropping mid-sequence has no effect on already-released channels.
- Divider (per channel):
  - Counter held 0 and clk_en_o[i]=0 while rst_n_o[i]=0.
  - Otherwise clk_en_o[i] pulses 1 cycle every DIV+1 cycles, first pulse on the first cycle after release.
  - DIV=0 gives clk_en_o[i] constant 1.
  - Writing DIVn restarts counter n at 0. Counters wrap at DIV.
- irq_o = IRQ_EN & (DONE | TIMEOUT), registered. W1C in the same cycle as a set: set wins.

Optional Feature:
RCU_SEQ_TIMEOUT_EN:
- Defined: a 16-bit counter runs in WAIT_LOCK. If 65535 cycles pass without lock, set TIMEOUT, go to IDLE, leave resets asserted; the counter clears on entering WAIT_LOCK.
- Undefined: WAIT_LOCK waits indefinitely; STAT[3] reads 0.

Decomposition:
- Package rcu_seq_pkg: register offset constants (CTRL/STAT/DLY/DIV base), STAT/CTRL bit-position constants, FSM state enum.
- Sub-module rcu_clk_en_div (one counter + enable logic), instantiated CHAN_NUM times in a generate loop.

Test Plan:
- Reset, then read all registers -> all 0, rst_n_o=0, clk_en_o=0; pready_o=1, pslverr_o=0.
- pll_lock_i=1, DLY=3, START -> rst_n_o goes 0001, 0011, 0111, 1111 at 4-cycle spacing; DONE=1; with IRQ_EN=1, irq_o=1; W1C DONE -> irq_o=0.
- DIV0=2, DIV1=0 after release -> clk_en_o[0] pulses every 3rd cycle, clk_en_o[1] constant 1; rewrite DIV0=4 mid-count -> pulse 5 cycles after the write.
- START with pll_lock_i=0 for 50 cycles -> no release, busy_o=1; raise lock -> sequence completes.
- During GAP after 2 channels released, pulse sys_rst_req_i for 5 cycles -> rst_n_o=0000 next cycle; after the falling edge, sequence auto-restarts from channel 0.
- (RCU_SEQ_TIMEOUT_EN) START with lock never asserted -> TIMEOUT=1 after 65535 cycles, busy_o=0, rst_n_o=0000, irq_o=1 if IRQ_EN.
